instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_if.sv | 32 +++
 rtl/instr_encoder.sv | 120 ++++++++++++
 2 files changed

// File: rtl/instr_encoder_if.sv
// Request/response bus of the instruction encoder: a field-level request in,
// one encoded word with its address and error flag out, both valid/ready.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_class;
    logic [2:0]  in_funct3;
    logic        in_sub;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;

    modport master (
        output in_valid, in_class, in_funct3, in_sub, in_rd, in_rs1, in_rs2, in_imm,
        input  in_ready,
        input  out_valid, out_instr, out_addr, out_err,
        output out_ready
    );

    modport slave (
        input  in_valid, in_class, in_funct3, in_sub, in_rd, in_rs1, in_rs2, in_imm,
        output in_ready,
        output out_valid, out_instr, out_addr, out_err,
        input  out_ready
    );
endinterface

// File: rtl/instr_encoder.sv
// RV32 instruction encoder: turns a class/field request into a 32-bit word,
// tags it with a running address and stops after an EBREAK until restarted.
module instr_encoder #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           restart,
    instr_encoder_if.slave bus,
    output logic           done
);
    localparam int unsigned XLEN = 32;

    localparam logic [2:0] CLS_OP     = 3'd0;
    localparam logic [2:0] CLS_OP_IMM = 3'd1;
    localparam logic [2:0] CLS_LOAD   = 3'd2;
    localparam logic [2:0] CLS_STORE  = 3'd3;
    localparam logic [2:0] CLS_JAL    = 3'd4;
    localparam logic [2:0] CLS_EBREAK = 3'd5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0]      F3_WORD     = 3'b010;
    localparam logic [6:0]      F7_SUB      = 7'b0100000;
    localparam logic [XLEN-1:0] EBREAK_WORD = 32'h0010_0073;

    typedef enum logic {RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic            ready;
    logic            accept;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] enc_word;
    logic            enc_err;
    logic            imm12_ok;
    logic            jimm_ok;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // Next state and input handshake; restart wins over a pending request
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        accept  = 1'b0;
        ready   = (state_q == RUN) && !restart && (!bus.out_valid || bus.out_ready);
        accept  = bus.in_valid && ready;
        if (state_q == RUN && accept && bus.in_class == CLS_EBREAK) state_d = DONE;
        else if (state_q == DONE && restart)                        state_d = RUN;
    end

    assign bus.in_ready = ready;
    assign done         = (state_q == DONE);

    // A value fits a signed field when all bits above the field's sign bit match it
    assign imm12_ok = (&bus.in_imm[31:11]) || !(|bus.in_imm[31:11]);
    assign jimm_ok  = ((&bus.in_imm[31:20]) || !(|bus.in_imm[31:20])) && !bus.in_imm[0];

    always_comb begin
        enc_word = '0;
        enc_err  = 1'b0;
        case (bus.in_class)
            CLS_OP: begin
                enc_err  = bus.in_sub && !(bus.in_funct3 == 3'b000 || bus.in_funct3 == 3'b101);
                enc_word = {(bus.in_sub ? F7_SUB : 7'b0), bus.in_rs2, bus.in_rs1,
                            bus.in_funct3, bus.in_rd, OPC_OP};
            end
            CLS_OP_IMM: begin
                enc_err  = !imm12_ok;
                enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OPC_OP_IMM};
            end
            CLS_LOAD: begin
                enc_err  = !imm12_ok;
                enc_word = {bus.in_imm[11:0], bus.in_rs1, F3_WORD, bus.in_rd, OPC_LOAD};
            end
            CLS_STORE: begin
                enc_err  = !imm12_ok;
                enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, F3_WORD,
                            bus.in_imm[4:0], OPC_STORE};
            end
            CLS_JAL: begin
                enc_err  = !jimm_ok;
                enc_word = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                            bus.in_imm[19:12], bus.in_rd, OPC_JAL};
            end
            CLS_EBREAK: enc_word = EBREAK_WORD;
            default:    enc_err  = 1'b1;
        endcase
        if (enc_err) enc_word = '0;
    end

    // Output word register and running address; a held word is never overwritten
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_instr <= '0;
            bus.out_err   <= 1'b0;
            bus.out_addr  <= RESET_ADDR;
            addr_q        <= RESET_ADDR;
        end else begin
            if (accept) begin
                bus.out_valid <= 1'b1;
                bus.out_instr <= enc_word;
                bus.out_err   <= enc_err;
                bus.out_addr  <= addr_q;
                addr_q        <= addr_q + XLEN'(4);
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (restart) addr_q <= RESET_ADDR;
        end
    end
endmodule
